fetch_decode: RTL

- Multicycle instruction fetch, decode and write-back sequencer directly upstream of the registered ALU.
- Fetches 16-bit instruction words from program ROM and holds accumulators A and B.
- Drives the ALU's opcode/in1/in2 inputs, then commits the ALU result (rWrData) or data-memory read data into A/B, or writes it to data memory.
- Non-pipelined: one instruction every 4 cycles (FETCH, DECODE, EXECUTE, WRITEBACK).

---
 rtl/fetch_decode.sv | 110 +++++++++++
 1 files changed

// File: rtl/fetch_decode.sv
// fetch_decode: four-cycle fetch/decode/execute/write-back sequencer feeding the registered ALU.
module fetch_decode #(
  parameter int PC_WIDTH    = 8,
  parameter int INSTR_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   iStall,
  output logic [PC_WIDTH-1:0]    oRomAddr,
  output logic                   oRomRd,
  input  logic [INSTR_WIDTH-1:0] iRomData,
  output logic [5:0]             oOpcode,
  output logic [9:0]             oIn1,
  output logic [9:0]             oIn2,
  input  logic [7:0]             iAluResult,
  output logic [9:0]             oMemAddr,
  output logic                   oMemRd,
  input  logic [7:0]             iMemRdData,
  output logic                   oMemWe,
  output logic [7:0]             oMemWrData,
  output logic [7:0]             oA,
  output logic [7:0]             oB,
  output logic [PC_WIDTH-1:0]    oPC
);
  localparam logic [5:0] OP_NOP  = 6'd0;
  localparam logic [5:0] OP_LDCA = 6'd1;
  localparam logic [5:0] OP_LDCB = 6'd2;
  localparam logic [5:0] OP_LDA  = 6'd3;
  localparam logic [5:0] OP_LDB  = 6'd4;
  localparam logic [5:0] OP_STA  = 6'd5;
  localparam logic [5:0] OP_STB  = 6'd6;
  localparam logic [5:0] OP_ADDA = 6'd7;
  localparam logic [5:0] OP_ADDB = 6'd8;

  typedef enum logic [1:0] {S_FETCH, S_DECODE, S_EXECUTE, S_WRITEBACK} state_t;

  state_t                 r_state;
  logic [PC_WIDTH-1:0]    r_pc;
  logic [INSTR_WIDTH-1:0] r_ir;
  logic [7:0]             r_a, r_b, r_mem_wr_data;
  logic [5:0]             r_opcode;
  logic                   r_rom_rd, r_mem_rd, r_mem_we;
  logic [5:0]             w_op, w_rom_op;
  logic                   w_store;

  assign w_op     = r_ir[INSTR_WIDTH-1 -: 6];
  assign w_rom_op = iRomData[INSTR_WIDTH-1 -: 6];
  assign w_store  = (w_op == OP_STA) || (w_op == OP_STB);

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state       <= S_FETCH;
      r_pc          <= '0;
      r_ir          <= '0;
      r_a           <= '0;
      r_b           <= '0;
      r_opcode      <= OP_NOP;
      r_rom_rd      <= 1'b0;
      r_mem_rd      <= 1'b0;
      r_mem_we      <= 1'b0;
      r_mem_wr_data <= '0;
    end else begin
      case (r_state)
        S_FETCH: begin
          r_rom_rd <= !iStall;
          if (!iStall) r_state <= S_DECODE;
        end
        S_DECODE: begin
          r_rom_rd <= 1'b0;
          r_ir     <= iRomData;
          r_pc     <= r_pc + PC_WIDTH'(1);
          r_opcode <= w_rom_op;
          r_mem_rd <= (w_rom_op == OP_LDA) || (w_rom_op == OP_LDB);
          r_state  <= S_EXECUTE;
        end
        S_EXECUTE: begin
          r_opcode <= OP_NOP;
          r_mem_rd <= 1'b0;
          r_mem_we <= w_store;
          // The ALU only passes A or B through for a store, so the register itself is the write data.
          if (w_store) r_mem_wr_data <= (w_op == OP_STB) ? r_b : r_a;
          r_state  <= S_WRITEBACK;
        end
        default: begin
          r_mem_we <= 1'b0;
          r_a <= (w_op == OP_LDCA) ? r_ir[7:0] :
                 (w_op == OP_LDA)  ? iMemRdData :
                 (w_op == OP_ADDA) ? iAluResult : r_a;
          r_b <= (w_op == OP_LDCB) ? r_ir[7:0] :
                 (w_op == OP_LDB)  ? iMemRdData :
                 (w_op == OP_ADDB) ? iAluResult : r_b;
          r_state <= S_FETCH;
        end
      endcase
    end
  end

  assign oRomAddr   = r_pc;
  assign oRomRd     = r_rom_rd;
  assign oOpcode    = r_opcode;
  assign oIn1       = {2'b00, r_a};
  assign oIn2       = {2'b00, r_b};
  assign oMemAddr   = r_ir[9:0];
  assign oMemRd     = r_mem_rd;
  assign oMemWe     = r_mem_we;
  assign oMemWrData = r_mem_wr_data;
  assign oA         = r_a;
  assign oB         = r_b;
  assign oPC        = r_pc;
endmodule
